// File: rtl/pcileech_bar_rsp_fifo.sv
// Read-completion buffer behind the AHCI BAR register-mimic stage: stores BAR read
// responses, presents them first-word-fall-through, and issues request credit.
module pcileech_bar_rsp_fifo #(
    parameter int DEPTH  = 8,
    parameter int CTX_W  = 88,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_fire,
    output logic                       req_credit,
    input  logic [CTX_W-1:0]           in_rsp_ctx,
    input  logic [DATA_W-1:0]          in_rsp_data,
    input  logic                       in_rsp_valid,
    output logic [CTX_W-1:0]           out_ctx,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_overflow,
    output logic                       err_credit,
    output logic                       err_orphan
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CTX_W + DATA_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [EW-1:0]     mem_q [DEPTH];

    logic [LW-1:0]     wp_q, wp_d;
    logic [LW-1:0]     rp_q, rp_d;
    logic [LW-1:0]     outs_q, outs_d;
    logic              out_valid_q, out_valid_d;
    logic [CTX_W-1:0]  out_ctx_q, out_ctx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_overflow_q, err_overflow_d;
    logic              err_credit_q, err_credit_d;
    logic              err_orphan_q, err_orphan_d;

    logic [LW-1:0]     level_w;
    logic [LW-1:0]     rp_nx;
    logic [LW:0]       credit_sum;
    logic [EW-1:0]     head_nx;
    logic              full;
    logic              pop;
    logic              push;
    logic              orphan;

    assign level_w    = wp_q - rp_q;
    assign full       = (level_w == DEPTH_L);
    assign pop        = out_valid_q & out_ready;
    assign push       = in_rsp_valid & (~full | pop);
    assign orphan     = in_rsp_valid & (outs_q == '0);
    assign rp_nx      = rp_q + LW'(1);
    assign head_nx    = mem_q[rp_nx[AW-1:0]];
    assign credit_sum = {1'b0, level_w} + {1'b0, outs_q};

    // Stored plus in-flight responses must never exceed the storage.
    assign req_credit = (credit_sum < {1'b0, DEPTH_L});

    always_comb begin
        wp_d           = wp_q;
        rp_d           = rp_q;
        out_ctx_d      = out_ctx_q;
        out_data_d     = out_data_q;
        outs_d         = outs_q;
        err_overflow_d = err_overflow_q;
        err_credit_d   = err_credit_q;
        err_orphan_d   = err_orphan_q;

        if (push) begin
            wp_d = wp_q + LW'(1);
        end
        if (pop) begin
            rp_d = rp_nx;
        end
        out_valid_d = (wp_d != rp_d);

        // Head register reloads only when the head changes: from the array when
        // another entry is already queued, otherwise from the incoming response.
        if (pop) begin
            if (level_w > LW'(1)) begin
                out_ctx_d  = head_nx[EW-1:DATA_W];
                out_data_d = head_nx[DATA_W-1:0];
            end else if (push) begin
                out_ctx_d  = in_rsp_ctx;
                out_data_d = in_rsp_data;
            end
        end else if (push && (level_w == '0)) begin
            out_ctx_d  = in_rsp_ctx;
            out_data_d = in_rsp_data;
        end

        // A response with nothing outstanding does not consume a request slot.
        if (in_rsp_valid && !orphan) begin
            if (!req_fire) begin
                outs_d = outs_q - LW'(1);
            end
        end else if (req_fire && (outs_q != DEPTH_L)) begin
            outs_d = outs_q + LW'(1);
        end

        if (in_rsp_valid && !push) begin
            err_overflow_d = 1'b1;
        end
        if (req_fire && !req_credit) begin
            err_credit_d = 1'b1;
        end
        if (orphan) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q           <= '0;
            rp_q           <= '0;
            outs_q         <= '0;
            out_valid_q    <= 1'b0;
            out_ctx_q      <= '0;
            out_data_q     <= '0;
            err_overflow_q <= 1'b0;
            err_credit_q   <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            outs_q         <= outs_d;
            out_valid_q    <= out_valid_d;
            out_ctx_q      <= out_ctx_d;
            out_data_q     <= out_data_d;
            err_overflow_q <= err_overflow_d;
            err_credit_q   <= err_credit_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    // Array contents need no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q[AW-1:0]] <= {in_rsp_ctx, in_rsp_data};
        end
    end

    assign out_ctx      = out_ctx_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign level        = level_w;
    assign err_overflow = err_overflow_q;
    assign err_credit   = err_credit_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_pcileech_bar_rsp_fifo.sv
// Bench for pcileech_bar_rsp_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pcileech_bar_rsp_fifo;

    localparam int DEPTH  = 4;
    localparam int CTX_W  = 88;
    localparam int DATA_W = 32;
    localparam int LW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_fire = 1'b0;
    logic              req_credit;
    logic [CTX_W-1:0]  in_rsp_ctx = '0;
    logic [DATA_W-1:0] in_rsp_data = '0;
    logic              in_rsp_valid = 1'b0;
    logic [CTX_W-1:0]  out_ctx;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     level;
    logic              err_overflow;
    logic              err_credit;
    logic              err_orphan;

    pcileech_bar_rsp_fifo #(.DEPTH(DEPTH), .CTX_W(CTX_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_fire     (req_fire),
        .req_credit   (req_credit),
        .in_rsp_ctx   (in_rsp_ctx),
        .in_rsp_data  (in_rsp_data),
        .in_rsp_valid (in_rsp_valid),
        .out_ctx      (out_ctx),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .err_overflow (err_overflow),
        .err_credit   (err_credit),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: queue of stored responses, count of outstanding reads, sticky flags.
    logic [CTX_W+DATA_W-1:0] mq[$];
    logic [DATA_W-1:0]       got[$];
    int  m_outs = 0;
    bit  m_ovf  = 1'b0;
    bit  m_cred = 1'b0;
    bit  m_orph = 1'b0;
    bit  m_pop, m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_outs = 0;
            m_ovf  = 1'b0;
            m_cred = 1'b0;
            m_orph = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_rsp_valid && ((mq.size() < DEPTH) || m_pop);
            if (in_rsp_valid && !m_push) m_ovf = 1'b1;
            if (req_fire && (mq.size() + m_outs >= DEPTH)) m_cred = 1'b1;
            if (in_rsp_valid && m_outs == 0) m_orph = 1'b1;
            if (in_rsp_valid && m_outs > 0) m_outs = m_outs - 1 + (req_fire ? 1 : 0);
            else if (req_fire && m_outs < DEPTH) m_outs = m_outs + 1;
            if (m_pop) begin
                got.push_back(out_data);
                void'(mq.pop_front());
            end
            if (m_push) mq.push_back({in_rsp_ctx, in_rsp_data});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_level", 128'(level), 128'(0));
            chk("rst_credit", 128'(req_credit), 128'(1));
            chk("rst_errs", 128'({err_overflow, err_credit, err_orphan}), 128'(0));
            chk("rst_out_data", 128'(out_data), 128'(0));
            chk("rst_out_ctx", 128'(out_ctx), 128'(0));
        end else begin
            chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
            chk("level", 128'(level), 128'(mq.size()));
            chk("req_credit", 128'(req_credit), 128'((mq.size() + m_outs) < DEPTH));
            chk("err_overflow", 128'(err_overflow), 128'(m_ovf));
            chk("err_credit", 128'(err_credit), 128'(m_cred));
            chk("err_orphan", 128'(err_orphan), 128'(m_orph));
            if (mq.size() != 0) begin
                chk("out_data", 128'(out_data), 128'(mq[0][DATA_W-1:0]));
                chk("out_ctx", 128'(out_ctx), 128'(mq[0][CTX_W+DATA_W-1:DATA_W]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d);
        in_rsp_valid = v;
        in_rsp_data  = d;
        in_rsp_ctx   = {24'hC0FFEE, d, ~d};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_fire = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill4(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, base + 32'(i));
            step();
        end
        drive(1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        logic pend;

        // Reset held with a response strobe present.
        rst_n = 1'b0;
        in_rsp_valid = 1'b1;
        in_rsp_ctx   = 88'h1;
        in_rsp_data  = 32'hC734FF01;
        step();
        step();
        chk("lit_rst_valid", 128'(out_valid), 128'(0));
        chk("lit_rst_credit", 128'(req_credit), 128'(1));
        rst_n = 1'b1;
        chk("lit_no_bypass", 128'(out_valid), 128'(0));
        step();
        in_rsp_valid = 1'b0;
        chk("lit_first_valid", 128'(out_valid), 128'(1));
        chk("lit_first_data", 128'(out_data), 128'(32'hC734FF01));
        chk("lit_first_ctx", 128'(out_ctx), 128'(88'h1));

        // Order under backpressure.
        do_reset();
        fill4(32'h10);
        chk("lit_full_level", 128'(level), 128'(4));
        step();
        step();
        chk("lit_hold_data", 128'(out_data), 128'(32'h10));
        chk("lit_full_credit", 128'(req_credit), 128'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_drain", 128'(out_data), 128'(32'h10 + 32'(i)));
            step();
        end
        chk("lit_drained", 128'(out_valid), 128'(0));

        // Overflow with no pop: response dropped.
        do_reset();
        fill4(32'h20);
        drive(1'b1, 32'h99);
        step();
        drive(1'b0, 32'h0);
        chk("lit_ovf_flag", 128'(err_overflow), 128'(1));
        chk("lit_ovf_level", 128'(level), 128'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_ovf_drain", 128'(out_data), 128'(32'h20 + 32'(i)));
            step();
        end
        chk("lit_ovf_empty", 128'(out_valid), 128'(0));

        // Full with simultaneous push and pop: both accepted.
        do_reset();
        fill4(32'h30);
        out_ready = 1'b1;
        drive(1'b1, 32'h99);
        step();
        drive(1'b0, 32'h0);
        chk("lit_pp_level", 128'(level), 128'(4));
        chk("lit_pp_noerr", 128'(err_overflow), 128'(0));
        for (int i = 1; i < 4; i++) begin
            chk("lit_pp_drain", 128'(out_data), 128'(32'h30 + 32'(i)));
            step();
        end
        chk("lit_pp_last", 128'(out_data), 128'(32'h99));
        step();
        chk("lit_pp_empty", 128'(out_valid), 128'(0));

        // Credit: BAR stage answers one cycle after each request.
        do_reset();
        pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_fire = req_credit;
            drive(pend, 32'h50 + 32'(i));
            pend = req_fire;
            step();
        end
        req_fire = 1'b0;
        drive(1'b0, 32'h0);
        chk("lit_cr_level", 128'(level), 128'(4));
        chk("lit_cr_low", 128'(req_credit), 128'(0));
        chk("lit_cr_noerr", 128'(err_credit), 128'(0));
        req_fire = 1'b1;
        step();
        req_fire = 1'b0;
        chk("lit_cr_err", 128'(err_credit), 128'(1));
        chk("lit_cr_noovf", 128'(err_overflow), 128'(0));
        chk("lit_cr_noorph", 128'(err_orphan), 128'(0));

        // Orphan response: flagged, stored, outstanding count stays at zero.
        do_reset();
        drive(1'b1, 32'h77);
        step();
        drive(1'b0, 32'h0);
        chk("lit_orph_flag", 128'(err_orphan), 128'(1));
        chk("lit_orph_level", 128'(level), 128'(1));
        req_fire = 1'b1;
        step();
        step();
        chk("lit_orph_credit3", 128'(req_credit), 128'(1));
        step();
        req_fire = 1'b0;
        chk("lit_orph_credit4", 128'(req_credit), 128'(0));
        chk("lit_orph_nocr", 128'(err_credit), 128'(0));

        // Wrap: 20 entries with alternating out_ready.
        do_reset();
        got.delete();
        sent = 0;
        for (int c = 0; c < 200; c++) begin
            out_ready = c[0];
            if (sent < 20 && (mq.size() < DEPTH || out_ready)) begin
                drive(1'b1, 32'h40 + 32'(sent));
                sent++;
            end else begin
                drive(1'b0, 32'h0);
            end
            step();
            chk("wrap_level_max", 128'(level <= 3'(DEPTH)), 128'(1));
            if (sent == 20 && mq.size() == 0) break;
        end
        drive(1'b0, 32'h0);
        out_ready = 1'b0;
        chk("wrap_count", 128'(got.size()), 128'(20));
        for (int i = 0; i < got.size(); i++) begin
            chk("wrap_order", 128'(got[i]), 128'(32'h40 + 32'(i)));
        end
        chk("wrap_empty", 128'(out_valid), 128'(0));

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60 + 32'(i));
            step();
        end
        drive(1'b0, 32'h0);
        chk("lit_mid_level", 128'(level), 128'(3));
        #3;
        rst_n = 1'b0;
        #1;
        chk("lit_mid_valid", 128'(out_valid), 128'(0));
        chk("lit_mid_lvl0", 128'(level), 128'(0));
        chk("lit_mid_credit", 128'(req_credit), 128'(1));
        step();
        rst_n = 1'b1;
        step();
        chk("lit_post_valid", 128'(out_valid), 128'(0));
        chk("lit_post_level", 128'(level), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
